multu_sequencer: RTL and testbench
==================================

# multu_sequencer

Control stage directly upstream of the shift-add multiplier. Accepts a MULTU request from the decode/execute stage and latches the operands. Drives the multiplier's `reset`/`Signal` inputs through a load, 32 MULTU shift steps and an OUT strobe, then captures the 64-bit product into architectural HI/LO registers. Also provides MTHI/MTLO writes and a `busy` stall to the pipeline.

## Interface

- `WIDTH`, default 32: operand width; the product is 2*WIDTH.
- `MULTU_CODE`, default 6'd25: Signal code for one shift/add step.
- `OUT_CODE`, default 6'b111111: Signal code that latches the product.
- `IDLE_CODE`, default 6'd0: Signal code when no step is active.

Ports:

- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request, qualified by `funct`.
- `funct`  in  6  operation code; only `MULTU_CODE` starts a multiply.
- `op_a`  in  WIDTH  multiplicand, sampled on the accepting edge.
- `op_b`  in  WIDTH  multiplier, sampled on the accepting edge.
- `wr_hi`  in  1  MTHI write enable.
- `wr_lo`  in  1  MTLO write enable.
- `wdata`  in  WIDTH  MTHI/MTLO write data.
- `mul_product`  in  2*WIDTH  multiplier `dataOut`.
- `mul_reset`  out  1  multiplier operand-load strobe.
- `mul_signal`  out  6  multiplier `Signal`.
- `mul_a`  out  WIDTH  latched multiplicand, to multiplier `dataA`.
- `mul_b`  out  WIDTH  latched multiplier, to multiplier `dataB`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; HI/LO hold the new product.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation

FSM states and outputs:

- **IDLE**
  - `mul_signal`=IDLE_CODE, `mul_reset`=0.
  - `start && funct==MULTU_CODE`: latch `op_a`→`mul_a` and `op_b`→`mul_b`/shadow; clear `count`; go to LOAD.
  - Any other `funct` with `start` is ignored.
- **LOAD** (1 cycle)
  - `mul_reset`=1, `mul_signal`=IDLE_CODE.
  - Go to RUN.
- **RUN**
  - `mul_signal`=MULTU_CODE.
  - Each edge: `count`++, shadow >>= 1.
  - Leave to OUT on the edge where `count`==WIDTH-1, giving exactly WIDTH RUN cycles.
- **OUT** (1 cycle)
  - `mul_signal`=OUT_CODE; the multiplier registers its product on this edge.
  - Go to CAPTURE.
- **CAPTURE** (1 cycle)
  - `mul_signal`=IDLE_CODE.
  - On the edge: `hi`←`mul_product[63:32]`, `lo`←`mul_product[31:0]`, `done`←1.
  - Go to IDLE.

Register and handshake rules:

- `done` is a registered pulse, high only in the cycle after CAPTURE.
- `count` is a 6-bit counter.
- `mul_a` and `mul_b` hold their values until the next accepted start.
- MTHI/MTLO:
  - In IDLE, `wr_hi` loads `hi`←`wdata` and `wr_lo` loads `lo`←`wdata`. Both may assert together.
  - In any other state, writes are dropped.
- `start` while `busy` is ignored. It is not queued.
- `start` in the cycle `done` is high is accepted, because the state is IDLE.
- `start` and MTHI/MTLO on the same IDLE edge: both take effect. The write lands now; the product overwrites HI/LO at CAPTURE.

## Timing

- Accepting edge E0; LOAD during E0→E1; RUN E1→E33; OUT E33→E34; CAPTURE E34→E35.
- HI/LO update at E35; `done`=1 and `busy`=0 in the cycle after E35.
- Fixed latency is 35 cycles from accept to HI/LO valid, or 3+N where N is the number of RUN cycles.
- `busy` is high from E0 through E35, i.e. 35 cycles.
- Reset at any edge:
  - state←IDLE, `count`←0.
  - `hi`, `lo`, `mul_a`, `mul_b`←0.
  - `mul_reset`, `done`←0; `mul_signal`←IDLE_CODE.
- Reset mid-operation aborts the multiply. No `done` is produced and no HI/LO update occurs.
- Reset wins over simultaneous `start` or MTHI/MTLO.

## Configuration

- `MULTU_EARLY_TERM_EN`
  - **Defined:** RUN also exits to OUT on the edge where the shifted shadow (shadow>>1) is zero, i.e. no set multiplier bits remain. RUN always lasts at least 1 cycle. `op_b`=1 or `op_b`=0 gives N=1, latency 4. `op_b`=0x00000100 gives N=9, latency 12.
  - **Undefined:** N is always WIDTH and the shadow register is not built.
- HI/LO results are identical in both builds.

## Test plan

- 3×5 MULTU, start at E0 → `busy` for 35 cycles, `mul_signal`=25 for 32 cycles then 63 for one, `done` after E35, `hi`=0x00000000, `lo`=0x0000000F.
- 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. 0x80000000×2 → `hi`=1, `lo`=0.
- `start` at cycle 10 of a run with new operands → ignored; result matches the first operands; a restart in the `done` cycle is accepted.
- MTHI 0x1234, MTLO 0x5678 in IDLE → `hi`/`lo` updated next edge; MTHI during `busy` → no change.
- `reset` asserted at RUN cycle 12 → next cycle IDLE, `busy`=0, `hi`=`lo`=0, no `done` pulse.
- With `MULTU_EARLY_TERM_EN`, 7×1 → `done` after E4, `lo`=7; without the macro → after E35.

Source files
------------

// File: rtl/multu_sequencer.sv
// rtl/multu_sequencer.sv - MULTU control sequencer: load, shift steps, OUT strobe, HI/LO capture (optional MULTU_EARLY_TERM_EN)
module multu_sequencer #(
    parameter int          WIDTH      = 32,
    parameter logic [5:0]  MULTU_CODE = 6'd25,
    parameter logic [5:0]  OUT_CODE   = 6'b111111,
    parameter logic [5:0]  IDLE_CODE  = 6'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5:0]           funct,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 wr_hi,
    input  logic                 wr_lo,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [2*WIDTH-1:0]   mul_product,
    output logic                 mul_reset,
    output logic [5:0]           mul_signal,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_OUT,
        S_CAPTURE
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_t     state;
    state_t     next_state;
    logic [5:0] count;
    logic       accept;
    logic       run_last;

`ifdef MULTU_EARLY_TERM_EN
    logic [WIDTH-1:0] shadow;

    // Shadow copy of the multiplier; once no set bits remain the rest of the steps add nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (accept) begin
            shadow <= op_b;
        end else if (state == S_RUN) begin
            shadow <= shadow >> 1;
        end
    end

    // Last RUN step: either the full width is done or the remaining multiplier bits are all zero.
    always_comb begin
        run_last = (count == LAST_STEP) || ((shadow >> 1) == '0);
    end
`else
    // Last RUN step: always after the full operand width.
    always_comb begin
        run_last = (count == LAST_STEP);
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and multiplier control strobes, decoded from the current state.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        mul_reset  = 1'b0;
        mul_signal = IDLE_CODE;
        case (state)
            S_IDLE: begin
                if (start && funct == MULTU_CODE) begin
                    accept     = 1'b1;
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                mul_reset  = 1'b1;
                next_state = S_RUN;
            end
            S_RUN: begin
                mul_signal = MULTU_CODE;
                if (run_last) begin
                    next_state = S_OUT;
                end
            end
            S_OUT: begin
                mul_signal = OUT_CODE;
                next_state = S_CAPTURE;
            end
            S_CAPTURE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Operand latches, step counter, HI/LO architectural registers and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 6'd0;
            mul_a <= '0;
            mul_b <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= (state == S_CAPTURE);
            if (accept) begin
                mul_a <= op_a;
                mul_b <= op_b;
                count <= 6'd0;
            end else if (state == S_RUN) begin
                count <= count + 6'd1;
            end
            // A start and an MTHI/MTLO on the same IDLE edge both land; the product overwrites later.
            if (state == S_CAPTURE) begin
                hi <= mul_product[2*WIDTH-1:WIDTH];
                lo <= mul_product[WIDTH-1:0];
            end else if (state == S_IDLE) begin
                if (wr_hi) begin
                    hi <= wdata;
                end
                if (wr_lo) begin
                    lo <= wdata;
                end
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_multu_sequencer.sv
// tb/tb_multu_sequencer.sv - directed table-driven bench for multu_sequencer with a shift-add multiplier model
module tb_multu_sequencer;

    localparam logic [5:0] C_MULTU = 6'd25;
    localparam logic [5:0] C_OUT   = 6'd63;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic [63:0] mul_product;
    logic        mul_reset;
    logic [5:0]  mul_signal;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    multu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .op_a(op_a), .op_b(op_b), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .mul_product(mul_product), .mul_reset(mul_reset), .mul_signal(mul_signal),
        .mul_a(mul_a), .mul_b(mul_b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // Behavioural shift-add multiplier: one add/shift per MULTU step, product registered on OUT.
    logic [63:0] m_acc, m_mcand, m_prod;
    logic [31:0] m_mplier;
    always @(posedge clk) begin
        if (reset) begin
            m_acc <= '0; m_mcand <= '0; m_mplier <= '0; m_prod <= '0;
        end else if (mul_reset) begin
            m_acc <= '0; m_mcand <= {32'd0, mul_a}; m_mplier <= mul_b;
        end else if (mul_signal == C_MULTU) begin
            if (m_mplier[0]) m_acc <= m_acc + m_mcand;
            m_mcand  <= m_mcand << 1;
            m_mplier <= m_mplier >> 1;
        end else if (mul_signal == C_OUT) begin
            m_prod <= m_acc;
        end
    end
    assign mul_product = m_prod;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    int n_vec = 0;
    int n_fail = 0;
    int r_done, r_busy, r_run, r_out, r_load;
    logic [31:0] r_hi_mid, r_lo_first;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_n(input logic [31:0] b);
        int top = 1;
        for (int i = 0; i < 32; i++) if (b[i]) top = i + 1;
`ifdef MULTU_EARLY_TERM_EN
        return top;
`else
        return (top > 0) ? 32 : 32;
`endif
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; funct = C_MULTU; op_a = a; op_b = b;
    endtask

    // Steps negedge by negedge until done; optionally injects a start plus MTHI at cycle inj_cyc.
    task automatic wait_done(input int inj_cyc, input logic [31:0] ia, input logic [31:0] ib);
        int cyc = 0;
        r_done = -1; r_busy = 0; r_run = 0; r_out = 0; r_load = 0;
        r_hi_mid = '0; r_lo_first = '0;
        while (r_done < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            if (cyc == inj_cyc) begin
                start = 1'b1; funct = C_MULTU; op_a = ia; op_b = ib;
                wr_hi = 1'b1; wdata = 32'hDEADBEEF;
            end
            if (cyc == 1) r_lo_first = lo;
            if (cyc == inj_cyc + 1) r_hi_mid = hi;
            if (busy) r_busy++;
            if (mul_signal == C_MULTU) r_run++;
            if (mul_signal == C_OUT) r_out++;
            if (mul_reset) r_load++;
            if (done) r_done = cyc;
        end
    endtask

    task automatic check_timing(input string tag, input logic [31:0] b);
        int n = exp_n(b);
        chk({tag, "_latency"}, 64'(r_done), 64'(n + 4));
        chk({tag, "_busy"}, 64'(r_busy), 64'(n + 3));
        chk({tag, "_run"}, 64'(r_run), 64'(n));
        chk({tag, "_out"}, 64'(r_out), 64'd1);
        chk({tag, "_load"}, 64'(r_load), 64'd1);
    endtask

    vec_t tv[8];

    initial begin
        int seen;
        int steps;
        tv[0] = '{32'd3,         32'd5,         32'h00000000, 32'h0000000F};
        tv[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 32'h00000001};
        tv[2] = '{32'h80000000,  32'd2,         32'h00000001, 32'h00000000};
        tv[3] = '{32'd7,         32'd1,         32'h00000000, 32'h00000007};
        tv[4] = '{32'h12345678,  32'h00000100,  32'h00000012, 32'h34567800};
        tv[5] = '{32'hFFFFFFFF,  32'h00000000,  32'h00000000, 32'h00000000};
        tv[6] = '{32'h00010000,  32'h00010000,  32'h00000001, 32'h00000000};
        tv[7] = '{32'd1000,      32'd1000,      32'h00000000, 32'h000F4240};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_signal", 64'(mul_signal), 64'd0);
        chk("rst_mul_reset", 64'(mul_reset), 64'd0);
        chk("rst_mul_ab", {mul_a, mul_b}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            launch(tv[i].a, tv[i].b);
            wait_done(0, '0, '0);
            check_timing($sformatf("v%0d", i), tv[i].b);
            chk($sformatf("v%0d_hi", i), 64'(hi), 64'(tv[i].hi));
            chk($sformatf("v%0d_lo", i), 64'(lo), 64'(tv[i].lo));
            chk($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
            chk($sformatf("v%0d_ops_held", i), {mul_a, mul_b}, {tv[i].a, tv[i].b});
        end

        // MTHI then MTLO then both together, all in IDLE.
        wr_hi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h5678;
        chk("mthi", 64'(hi), 64'h1234);
        chk("mthi_lo_kept", 64'(lo), 64'h000F4240);
        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hA5A5;
        chk("mtlo", 64'(lo), 64'h5678);
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("mt_both", {hi, lo}, {32'hA5A5, 32'hA5A5});

        // Non-MULTU funct is ignored.
        start = 1'b1; funct = 6'd24; op_a = 32'd9; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        chk("funct_ignored", 64'(busy), 64'd0);

        // Start and MTHI while busy are dropped; restart in the done cycle is accepted.
        launch(32'd7, 32'd9);
        wait_done(10, 32'd11, 32'd13);
        check_timing("ign", 32'd9);
        chk("ign_mthi_dropped", 64'(r_hi_mid), 64'hA5A5);
        chk("ign_result", {hi, lo}, {32'd0, 32'd63});
        chk("ign_ops", {mul_a, mul_b}, {32'd7, 32'd9});
        launch(32'h10, 32'h10);
        wait_done(0, '0, '0);
        check_timing("rest", 32'h10);
        chk("rest_result", {hi, lo}, {32'd0, 32'h100});

        // Start and MTLO on the same IDLE edge: write lands now, product later.
        @(negedge clk);
        launch(32'd6, 32'd7);
        wr_lo = 1'b1; wdata = 32'h55;
        wait_done(0, '0, '0);
        chk("same_edge_lo_write", 64'(r_lo_first), 64'h55);
        chk("same_edge_result", {hi, lo}, {32'd0, 32'd42});

        // Reset at RUN cycle 12 aborts with no done and clears HI/LO.
        @(negedge clk);
        wr_hi = 1'b1; wdata = 32'h77;
        @(negedge clk);
        wr_hi = 1'b0;
        launch(32'h1234, 32'h5678);
        steps = 0;
        for (int c = 0; c < 60 && steps < 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mul_signal == C_MULTU) steps++;
        end
        chk("abort_reached_run12", 64'(steps), 64'd12);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_signal", 64'(mul_signal), 64'd0);
        chk("abort_ops", {mul_a, mul_b}, 64'd0);
        seen = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);

        // Reset beats a simultaneous start and MTHI.
        reset = 1'b1; launch(32'd3, 32'd3); wr_hi = 1'b1; wdata = 32'h99;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; wr_hi = 1'b0;
        chk("rst_wins_busy", 64'(busy), 64'd0);
        chk("rst_wins_hi", 64'(hi), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
